spi_xfer_ctrl: RTL and testbench

Transfer sequencer for the SPI host shift engine.
- Generates the serial clock and the one-cycle pos_edge/neg_edge strobes consumed by the shift register.
- Issues the single-cycle go pulse and frames each character with slave-select setup/hold delays.
- Reports completion through a done pulse and a sticky, maskable interrupt.
- Sits between the register interface (start/config) and the shift engine (go/tip/last/edges/s_clk).

---
 rtl/spi_xfer_ctrl_if.sv | 35 +++
 rtl/spi_xfer_ctrl.sv | 130 +++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_ctrl_if.sv
// Handshake/config bundle between the register block, the transfer sequencer
// and the SPI shift engine.
interface spi_xfer_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int CS_W  = 8,
  parameter int DLY_W = 8
);
  logic             start;
  logic [DIV_W-1:0] divider;
  logic [CS_W-1:0]  ss_sel;
  logic             auto_ss;
  logic [DLY_W-1:0] cs_setup;
  logic [DLY_W-1:0] cs_hold;
  logic             ie;
  logic             irq_clr;
  logic             tip;
  logic             go;
  logic             pos_edge;
  logic             neg_edge;
  logic             sclk_o;
  logic [CS_W-1:0]  ss_n_o;
  logic             busy;
  logic             done;
  logic             irq;

  modport master (
    output start, divider, ss_sel, auto_ss, cs_setup, cs_hold, ie, irq_clr, tip,
    input  go, pos_edge, neg_edge, sclk_o, ss_n_o, busy, done, irq
  );

  modport slave (
    input  start, divider, ss_sel, auto_ss, cs_setup, cs_hold, ie, irq_clr, tip,
    output go, pos_edge, neg_edge, sclk_o, ss_n_o, busy, done, irq
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: frames one character with slave-select setup/hold,
// generates sclk plus edge strobes for the shift engine, and reports completion.
module spi_xfer_ctrl #(
  parameter int DIV_W = 16,
  parameter int CS_W  = 8,
  parameter int DLY_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_xfer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, GO, XFER, HOLD, DONE} state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DLY_W-1:0] hold_reg;
  logic [DIV_W-1:0] clk_cnt_reg;
  logic [DLY_W-1:0] dly_cnt_reg;
  logic             sclk_reg;
  logic [CS_W-1:0]  ss_n_reg;
  logic             go_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             irq_reg;
  logic             edge_due;

  // Value of the slave selects for the state being entered.
  function automatic logic [CS_W-1:0] ss_drive(input logic framed, input logic auto_mode,
                                               input logic [CS_W-1:0] sel);
    return (auto_mode && !framed) ? {CS_W{1'b1}} : ~sel;
  endfunction

  // Once tip drops, only a high sclk still needs its trailing falling edge.
  assign edge_due      = (state_reg == XFER) && (clk_cnt_reg == '0) && (bus.tip || sclk_reg);
  assign bus.pos_edge  = edge_due && !sclk_reg;
  assign bus.neg_edge  = edge_due && sclk_reg;
  assign bus.sclk_o    = sclk_reg;
  assign bus.ss_n_o    = ss_n_reg;
  assign bus.go        = go_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.irq       = irq_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      div_reg     <= '0;
      hold_reg    <= '0;
      clk_cnt_reg <= '0;
      dly_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
      ss_n_reg    <= '1;
      go_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      go_reg   <= 1'b0;
      done_reg <= 1'b0;

      // A set coinciding with a clear must win, so the set is tested first.
      if (state_reg == DONE && bus.ie) begin
        irq_reg <= 1'b1;
      end else if (bus.irq_clr) begin
        irq_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          ss_n_reg <= ss_drive(1'b0, bus.auto_ss, bus.ss_sel);
          if (bus.start) begin
            div_reg     <= bus.divider;
            hold_reg    <= bus.cs_hold;
            dly_cnt_reg <= bus.cs_setup;
            busy_reg    <= 1'b1;
            ss_n_reg    <= ss_drive(1'b1, bus.auto_ss, bus.ss_sel);
            state_reg   <= SETUP;
          end
        end
        SETUP: begin
          ss_n_reg <= ss_drive(1'b1, bus.auto_ss, bus.ss_sel);
          if (dly_cnt_reg == '0) begin
            go_reg    <= 1'b1;
            state_reg <= GO;
          end else begin
            dly_cnt_reg <= dly_cnt_reg - DLY_W'(1);
          end
        end
        GO: begin
          ss_n_reg    <= ss_drive(1'b1, bus.auto_ss, bus.ss_sel);
          clk_cnt_reg <= div_reg;
          state_reg   <= XFER;
        end
        XFER: begin
          ss_n_reg <= ss_drive(1'b1, bus.auto_ss, bus.ss_sel);
          if (edge_due) begin
            clk_cnt_reg <= div_reg;
            sclk_reg    <= ~sclk_reg;
          end else if (clk_cnt_reg != '0) begin
            clk_cnt_reg <= clk_cnt_reg - DIV_W'(1);
          end
          if (!bus.tip && !sclk_reg) begin
            dly_cnt_reg <= hold_reg;
            state_reg   <= HOLD;
          end
        end
        HOLD: begin
          if (dly_cnt_reg == '0) begin
            done_reg  <= 1'b1;
            ss_n_reg  <= ss_drive(1'b0, bus.auto_ss, bus.ss_sel);
            state_reg <= DONE;
          end else begin
            ss_n_reg    <= ss_drive(1'b1, bus.auto_ss, bus.ss_sel);
            dly_cnt_reg <= dly_cnt_reg - DLY_W'(1);
          end
        end
        DONE: begin
          ss_n_reg  <= ss_drive(1'b0, bus.auto_ss, bus.ss_sel);
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: table of transfers scored at done,
// plus hand sequences for idle/reset, irq stickiness and reset abort.
module tb_spi_xfer_ctrl;
  localparam int DIV_W = 16;
  localparam int CS_W  = 8;
  localparam int DLY_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_xfer_ctrl_if #(.DIV_W(DIV_W), .CS_W(CS_W), .DLY_W(DLY_W)) bus ();

  spi_xfer_ctrl #(.DIV_W(DIV_W), .CS_W(CS_W), .DLY_W(DLY_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         div;
    int         setup;
    int         hold;
    logic [7:0] sel;
    logic       auto_ss;
    logic       ie;
    logic       chg_div;
    logic       poke;
  } vec_t;

  typedef struct {
    int         id;
    int         half;
    int         go_gap;
    int         done_gap;
    logic [7:0] ss_frame;
    logic [7:0] ss_done;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[5];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Shift-engine stub: tip rises after go, drops on the 4th pos_edge.
  int pcount;
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.tip <= 1'b0;
      pcount  <= 0;
    end else if (bus.go) begin
      bus.tip <= 1'b1;
      pcount  <= 0;
    end else if (bus.pos_edge && bus.tip) begin
      pcount <= pcount + 1;
      if (pcount == 3) bus.tip <= 1'b0;
    end
  end

  // Monitor / scoreboard consumer, sampling mid-cycle.
  int   cyc = 0;
  logic busy_q = 1'b0;
  int   rise_cyc, go_cyc, last_neg, last_edge;
  int   pos_cnt, neg_cnt, go_cnt, done_total = 0;
  logic [7:0] ss_rise;
  logic spacing_bad = 1'b0;
  logic strobe_bad = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      busy_q = 1'b0;
    end else begin
      if (bus.pos_edge && bus.neg_edge) strobe_bad = 1'b1;
      if ((bus.pos_edge || bus.neg_edge) && !bus.busy) strobe_bad = 1'b1;
      if (bus.busy && !busy_q) begin
        rise_cyc  = cyc;
        ss_rise   = bus.ss_n_o;
        pos_cnt   = 0;
        neg_cnt   = 0;
        go_cnt    = 0;
        last_edge = -1;
        spacing_bad = 1'b0;
      end
      if (bus.go) begin
        go_cyc = cyc;
        go_cnt++;
      end
      if (bus.pos_edge || bus.neg_edge) begin
        if (last_edge >= 0 && sb.size() > 0 && (cyc - last_edge) != sb[0].half) spacing_bad = 1'b1;
        last_edge = cyc;
      end
      if (bus.pos_edge) pos_cnt++;
      if (bus.neg_edge) begin
        neg_cnt++;
        last_neg = cyc;
      end
      if (bus.done) begin
        done_total++;
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          $display("xfer %0d: pos=%0d neg=%0d go_gap=%0d done_gap=%0d ss=%02h", e.id, pos_cnt,
                   neg_cnt, go_cyc - rise_cyc, cyc - last_neg, ss_rise);
          check("pos_edge_count", pos_cnt, 4);
          check("neg_edge_count", neg_cnt, 4);
          check("go_pulse_count", go_cnt, 1);
          check("ss_to_go_cycles", go_cyc - rise_cyc, e.go_gap);
          check("neg_to_done_cycles", cyc - last_neg, e.done_gap);
          check("edge_spacing_ok", spacing_bad, 0);
          check("strobe_rules_ok", strobe_bad, 0);
          check("sclk_idle_at_done", bus.sclk_o, 0);
          check("ss_while_framed", ss_rise, e.ss_frame);
          check("ss_at_done", bus.ss_n_o, e.ss_done);
        end
      end
      busy_q = bus.busy;
    end
  end

  task automatic wait_sig(input string name, input bit which_done, input int limit);
    int n = 0;
    while (!(which_done ? bus.done : bus.go) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check(name, 64'd0, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id, input bit clr_at_done);
    exp_t e;
    @(negedge clk);
    bus.divider  = 16'(v.div);
    bus.cs_setup = 8'(v.setup);
    bus.cs_hold  = 8'(v.hold);
    bus.ss_sel   = v.sel;
    bus.auto_ss  = v.auto_ss;
    bus.ie       = v.ie;
    e.id       = id;
    e.half     = v.div + 1;
    e.go_gap   = v.setup + 1;
    e.done_gap = v.hold + 3;
    e.ss_frame = ~v.sel;
    e.ss_done  = v.auto_ss ? 8'hFF : ~v.sel;
    sb.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_sig("go_timeout", 1'b0, 200);
    if (v.chg_div) bus.divider = 16'd0;
    if (v.poke) begin
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_sig("done_timeout", 1'b1, 2000);
    if (clr_at_done) bus.irq_clr = 1'b1;
    @(negedge clk);
    bus.irq_clr = 1'b0;
  endtask

  initial begin
    int idle_bad;
    int dones_before;
    vec_t v;

    tbl[0] = '{0, 0, 0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{3, 0, 0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{0, 5, 2, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1, 2, 1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{2, 1, 3, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};

    bus.start = 1'b0; bus.divider = '0; bus.ss_sel = 8'h01; bus.auto_ss = 1'b1;
    bus.cs_setup = '0; bus.cs_hold = '0; bus.ie = 1'b0; bus.irq_clr = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_go", bus.go, 0);
    check("rst_pos_edge", bus.pos_edge, 0);
    check("rst_neg_edge", bus.neg_edge, 0);
    check("rst_sclk", bus.sclk_o, 0);
    check("rst_ss_n", bus.ss_n_o, 8'hFF);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_irq", bus.irq, 0);
    rst_n = 1'b1;

    idle_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.pos_edge || bus.neg_edge || bus.busy || bus.done || bus.go || bus.sclk_o ||
          bus.ss_n_o != 8'hFF) idle_bad++;
    end
    check("idle_quiet_cycles_bad", idle_bad, 0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], i, 1'b0);
    check("irq_off_when_ie0", bus.irq, 0);

    v = '{0, 0, 0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0};
    run_vec(v, 5, 1'b0);
    check("irq_set_after_done", bus.irq, 1);
    repeat (5) @(negedge clk);
    check("irq_sticky", bus.irq, 1);
    bus.ie = 1'b0;
    repeat (3) @(negedge clk);
    check("irq_kept_ie0", bus.irq, 1);
    v.ie = 1'b1;
    run_vec(v, 6, 1'b1);
    check("irq_set_beats_clr", bus.irq, 1);
    bus.irq_clr = 1'b1;
    @(negedge clk);
    bus.irq_clr = 1'b0;
    @(negedge clk);
    check("irq_cleared", bus.irq, 0);
    check("done_pulses_total", done_total, 7);

    // Abort in the middle of XFER.
    dones_before = done_total;
    bus.divider = 16'd2; bus.cs_setup = '0; bus.cs_hold = '0;
    bus.ss_sel = 8'h0F; bus.auto_ss = 1'b0; bus.ie = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_sig("abort_go_timeout", 1'b0, 200);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_sclk", bus.sclk_o, 0);
    check("abort_ss_n", bus.ss_n_o, 8'hFF);
    check("abort_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_total, dones_before);
    check("abort_no_irq", bus.irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
